// File: rtl/sprite_pos_ctrl.sv
// rtl/sprite_pos_ctrl.sv - once-per-frame position owner for one player sprite
//
// Purpose:
//   Collects signed move requests from game logic at any time, sums them into
//   saturating accumulators, and applies the summed move to the sprite's
//   top-left position once per frame on the renderer's frame-start pulse.
//   This keeps the drawn position stable for the whole frame. The result is
//   clamped to the playfield box. With SPRITE_POS_WRAP_EN defined, it wraps
//   around the box instead.
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_frame_start  one-cycle pulse at the frame boundary
//   i_move_valid   move request valid
//   o_move_ready   move request accepted when valid && ready
//   i_move_dx      signed x delta (two's complement, 8 bit)
//   i_move_dy      signed y delta (two's complement, 8 bit)
//   i_recenter     level; sampled at snapshot, the commit loads X_INIT/Y_INIT
//   o_x, o_y       committed sprite left x / top y
//   o_update       one-cycle pulse when o_x or o_y changed at commit
//   o_busy         high while a commit sequence is in flight
//
// Build option:
//   SPRITE_POS_WRAP_EN  wrap around the playfield instead of clamping

module sprite_pos_ctrl #(
   parameter int X_MIN    = 320,
   parameter int X_MAX    = 1280,
   parameter int Y_MIN    = 210,
   parameter int Y_MAX    = 690,
   parameter int SPR_W    = 60,
   parameter int SPR_H    = 60,
   parameter int X_INIT   = 800,
   parameter int Y_INIT   = 450,
   parameter int MAX_STEP = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_frame_start,
   input  logic        i_move_valid,
   output logic        o_move_ready,
   input  logic [7:0]  i_move_dx,
   input  logic [7:0]  i_move_dy,
   input  logic        i_recenter,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_update,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SNAP,
      S_CALC,
      S_COMMIT
   } state_t;

   // Legal top-left range: the whole sprite must stay inside the box.
   localparam logic signed [13:0] X_LO  = 14'(X_MIN);
   localparam logic signed [13:0] X_HI  = 14'(X_MAX - SPR_W);
   localparam logic signed [13:0] Y_LO  = 14'(Y_MIN);
   localparam logic signed [13:0] Y_HI  = 14'(Y_MAX - SPR_H);
   localparam logic signed [13:0] X_RST = 14'(X_INIT);
   localparam logic signed [13:0] Y_RST = 14'(Y_INIT);

   localparam logic signed [10:0] STEP_P = 11'(MAX_STEP);
   localparam logic signed [10:0] STEP_N = 11'(-MAX_STEP);

   if (X_INIT < X_MIN || X_INIT > X_MAX - SPR_W ||
       Y_INIT < Y_MIN || Y_INIT > Y_MAX - SPR_H) begin : g_init_range_chk
      $error("sprite_pos_ctrl: X_INIT/Y_INIT outside the legal playfield range");
   end

   if (MAX_STEP < 1 || MAX_STEP > 511) begin : g_step_range_chk
      $error("sprite_pos_ctrl: MAX_STEP must fit the 10-bit signed accumulator");
   end

`ifdef SPRITE_POS_WRAP_EN
   // One wrap correction is only enough when a frame's move is shorter than
   // the span.
   if (MAX_STEP >= X_MAX - SPR_W - X_MIN + 1 ||
       MAX_STEP >= Y_MAX - SPR_H - Y_MIN + 1) begin : g_wrap_span_chk
      $error("sprite_pos_ctrl: MAX_STEP must be smaller than the wrap span");
   end
`endif

   state_t             state;
   logic signed [9:0]  acc_x;
   logic signed [9:0]  acc_y;
   logic signed [9:0]  work_x;
   logic signed [9:0]  work_y;
   logic               recenter_l;
   logic signed [13:0] nx_r;
   logic signed [13:0] ny_r;
   logic               move_hs;

   assign move_hs = i_move_valid && o_move_ready;

   // Accumulate one sign-extended delta, saturating at +/-MAX_STEP.
   function automatic logic signed [9:0] sat_add(input logic signed [9:0] a,
                                                 input logic [7:0]        d);
      logic signed [10:0] s;
      s = $signed({a[9], a}) + $signed({{3{d[7]}}, d});
      if (s > STEP_P) begin
         s = STEP_P;
      end else if (s < STEP_N) begin
         s = STEP_N;
      end
      return s[9:0];
   endfunction

   // Apply one frame's move to one axis, then bring it back into [lo, hi].
   function automatic logic signed [13:0] next_pos(input logic [11:0]        pos,
                                                   input logic signed [9:0]  d,
                                                   input logic signed [13:0] lo,
                                                   input logic signed [13:0] hi);
      logic signed [13:0] s;
      s = $signed({2'b00, pos}) + $signed({{4{d[9]}}, d});
`ifdef SPRITE_POS_WRAP_EN
      if (s > hi) begin
         s = s - (hi - lo + 14'sd1);
      end else if (s < lo) begin
         s = s + (hi - lo + 14'sd1);
      end
`else
      if (s > hi) begin
         s = hi;
      end else if (s < lo) begin
         s = lo;
      end
`endif
      return s;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         acc_x        <= '0;
         acc_y        <= '0;
         work_x       <= '0;
         work_y       <= '0;
         recenter_l   <= 1'b0;
         nx_r         <= X_RST;
         ny_r         <= Y_RST;
         o_x          <= 12'(X_INIT);
         o_y          <= 12'(Y_INIT);
         o_move_ready <= 1'b1;
         o_update     <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         o_update <= 1'b0;
         case (state)
            S_IDLE: begin
               // A handshake in the frame-start cycle lands in acc before
               // SNAP reads it, so it joins this frame's move.
               if (move_hs) begin
                  acc_x <= sat_add(acc_x, i_move_dx);
                  acc_y <= sat_add(acc_y, i_move_dy);
               end
               if (i_frame_start) begin
                  state        <= S_SNAP;
                  o_move_ready <= 1'b0;
                  o_busy       <= 1'b1;
               end
            end
            S_SNAP: begin
               work_x     <= acc_x;
               work_y     <= acc_y;
               recenter_l <= i_recenter;
               acc_x      <= '0;
               acc_y      <= '0;
               state      <= S_CALC;
            end
            S_CALC: begin
               if (recenter_l) begin
                  nx_r <= X_RST;
                  ny_r <= Y_RST;
               end else begin
                  nx_r <= next_pos(o_x, work_x, X_LO, X_HI);
                  ny_r <= next_pos(o_y, work_y, Y_LO, Y_HI);
               end
               state <= S_CALC == state ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
               o_x          <= nx_r[11:0];
               o_y          <= ny_r[11:0];
               o_update     <= (nx_r != $signed({2'b00, o_x})) ||
                               (ny_r != $signed({2'b00, o_y}));
               o_move_ready <= 1'b1;
               o_busy       <= 1'b0;
               state        <= S_IDLE;
            end
            default: begin
               state        <= S_IDLE;
               o_move_ready <= 1'b1;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
